// File: rtl/debug_values_ctrl.sv
// Debugger value bank and CPU run controller: ID-addressed registers, multi-step,
// free-run with address breakpoints, host halt, and per-instruction CPU snapshot.
module debug_values_ctrl #(
   parameter int DATA_WIDTH       = 16,
   parameter int NUM_BREAKPOINTS  = 4,
   parameter int STEP_COUNT_WIDTH = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_ena,
   input  logic                  i_wea,
   input  logic [15:0]           i_id,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic [15:0]           i_cpu_address,
   input  logic [7:0]            i_cpu_data,
   input  logic                  i_cpu_rw,
   input  logic                  i_cpu_sync,
   input  logic                  i_cpu_irq_n,
   input  logic                  i_cpu_nmi_n,
   input  logic [47:0]           i_cpu_regs,
   output logic                  o_cpu_start_step,
   input  logic                  i_cpu_step_completed,
   output logic                  o_halted
);
   localparam int BW  = (NUM_BREAKPOINTS > 1) ? $clog2(NUM_BREAKPOINTS) : 1;
   localparam int SCW = STEP_COUNT_WIDTH;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEP = 2'd1, S_RUN = 2'd2} state_t;

   state_t                               state_q;
   logic                                 start_q, halted_q;
   logic [SCW-1:0]                       step_count_q, steps_rem_q;
   logic [1:0]                           halt_reason_q;
   logic [BW-1:0]                        bp_hit_q;
   logic [15:0]                          snap_addr_q;
   logic [7:0]                           snap_data_q;
   logic [3:0]                           snap_flags_q;
   logic [47:0]                          snap_regs_q;
   logic [NUM_BREAKPOINTS-1:0][15:0]     bp_addr_q;
   logic [NUM_BREAKPOINTS-1:0]           bp_en_q;

   logic          wr, ctrl_wr, cmd_step, cmd_run, cmd_halt, bp_found, done;
   logic [BW-1:0] bp_idx;

   assign wr       = i_ena & i_wea;
   assign ctrl_wr  = wr && (i_id == 16'd1);
   assign cmd_step = ctrl_wr && (i_data == DATA_WIDTH'(1));
   assign cmd_run  = ctrl_wr && (i_data == DATA_WIDTH'(2));
   assign cmd_halt = ctrl_wr && (i_data == DATA_WIDTH'(3));
   assign done     = i_cpu_step_completed;

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      bp_found = 1'b0;
      bp_idx   = '0;
      for (int k = NUM_BREAKPOINTS - 1; k >= 0; k--) begin
         if (bp_en_q[k] && (i_cpu_address == bp_addr_q[k])) begin
            bp_found = 1'b1;
            bp_idx   = BW'(k);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= S_IDLE;
         start_q       <= 1'b0;
         halted_q      <= 1'b1;
         step_count_q  <= SCW'(1);
         steps_rem_q   <= '0;
         halt_reason_q <= 2'd0;
         bp_hit_q      <= '0;
         snap_addr_q   <= '0;
         snap_data_q   <= '0;
         snap_flags_q  <= '0;
         snap_regs_q   <= '0;
         bp_addr_q     <= '0;
         bp_en_q       <= '0;
      end else begin
         if (done) begin
            snap_addr_q  <= i_cpu_address;
            snap_data_q  <= i_cpu_data;
            snap_flags_q <= {i_cpu_nmi_n, i_cpu_irq_n, i_cpu_sync, i_cpu_rw};
            snap_regs_q  <= i_cpu_regs;
         end
         if (wr) begin
            for (int k = 0; k < NUM_BREAKPOINTS; k++) begin
               if (i_id == 16'(16 + 2*k)) bp_addr_q[k] <= i_data[15:0];
               if (i_id == 16'(17 + 2*k)) bp_en_q[k]   <= i_data[0];
            end
         end
         case (state_q)
            S_IDLE: begin
               if (cmd_step) begin
                  state_q       <= S_STEP;
                  start_q       <= 1'b1;
                  halted_q      <= 1'b0;
                  steps_rem_q   <= step_count_q;
                  halt_reason_q <= 2'd0;
               end else if (cmd_run) begin
                  state_q       <= S_RUN;
                  start_q       <= 1'b1;
                  halted_q      <= 1'b0;
                  halt_reason_q <= 2'd0;
               end else if (wr && (i_id == 16'd2)) begin
                  step_count_q <= (i_data[SCW-1:0] == '0) ? SCW'(1) : i_data[SCW-1:0];
               end
            end
            default: begin
               if (done && (state_q == S_STEP) && (steps_rem_q != '0))
                  steps_rem_q <= steps_rem_q - SCW'(1);
               // Host halt outranks breakpoint, which outranks count exhaustion.
               if (cmd_halt) begin
                  state_q       <= S_IDLE;
                  start_q       <= 1'b0;
                  halted_q      <= 1'b1;
                  halt_reason_q <= 2'd3;
               end else if (done && bp_found) begin
                  state_q       <= S_IDLE;
                  start_q       <= 1'b0;
                  halted_q      <= 1'b1;
                  halt_reason_q <= 2'd2;
                  bp_hit_q      <= bp_idx;
               end else if (done && (state_q == S_STEP) && (steps_rem_q == SCW'(1))) begin
                  state_q       <= S_IDLE;
                  start_q       <= 1'b0;
                  halted_q      <= 1'b1;
                  halt_reason_q <= 2'd1;
               end
            end
         endcase
      end
   end

   assign o_cpu_start_step = start_q;
   assign o_halted         = halted_q;

   always_comb begin
      o_data = '0;
      if (i_ena) begin
         case (i_id)
            16'd1:   o_data = DATA_WIDTH'(state_q);
            16'd2:   o_data = DATA_WIDTH'(step_count_q);
            16'd3:   o_data = DATA_WIDTH'(steps_rem_q);
            16'd4:   o_data = DATA_WIDTH'(halt_reason_q);
            16'd5:   o_data = DATA_WIDTH'(bp_hit_q);
            16'd6:   o_data = DATA_WIDTH'(snap_addr_q);
            16'd7:   o_data = DATA_WIDTH'(snap_data_q);
            16'd8:   o_data = DATA_WIDTH'(snap_flags_q);
            16'd9:   o_data = DATA_WIDTH'(snap_regs_q[7:0]);
            16'd10:  o_data = DATA_WIDTH'(snap_regs_q[15:8]);
            16'd11:  o_data = DATA_WIDTH'(snap_regs_q[23:16]);
            16'd12:  o_data = DATA_WIDTH'(snap_regs_q[31:24]);
            16'd13:  o_data = DATA_WIDTH'(snap_regs_q[39:32]);
            16'd14:  o_data = DATA_WIDTH'(snap_regs_q[47:40]);
            default: begin
               for (int k = 0; k < NUM_BREAKPOINTS; k++) begin
                  if (i_id == 16'(16 + 2*k)) o_data = DATA_WIDTH'(bp_addr_q[k]);
                  if (i_id == 16'(17 + 2*k)) o_data = DATA_WIDTH'(bp_en_q[k]);
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_debug_values_ctrl.sv
// Directed bench for debug_values_ctrl: stepping, breakpoints, host halt, reset.
module tb_debug_values_ctrl;
   logic        i_clk = 1'b0;
   logic        i_reset, i_ena, i_wea;
   logic [15:0] i_id, i_data, o_data, i_cpu_address;
   logic [7:0]  i_cpu_data;
   logic        i_cpu_rw, i_cpu_sync, i_cpu_irq_n, i_cpu_nmi_n;
   logic [47:0] i_cpu_regs;
   logic        o_cpu_start_step, i_cpu_step_completed, o_halted;

   int n_assert = 0;
   int n_fail   = 0;

   debug_values_ctrl #(.DATA_WIDTH(16), .NUM_BREAKPOINTS(4), .STEP_COUNT_WIDTH(16)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_ena(i_ena), .i_wea(i_wea), .i_id(i_id),
      .i_data(i_data), .o_data(o_data), .i_cpu_address(i_cpu_address),
      .i_cpu_data(i_cpu_data), .i_cpu_rw(i_cpu_rw), .i_cpu_sync(i_cpu_sync),
      .i_cpu_irq_n(i_cpu_irq_n), .i_cpu_nmi_n(i_cpu_nmi_n), .i_cpu_regs(i_cpu_regs),
      .o_cpu_start_step(o_cpu_start_step), .i_cpu_step_completed(i_cpu_step_completed),
      .o_halted(o_halted)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [15:0] id, input logic [15:0] d);
      i_ena = 1'b1; i_wea = 1'b1; i_id = id; i_data = d;
      @(posedge i_clk); #1;
      i_ena = 1'b0; i_wea = 1'b0;
   endtask

   task automatic rd(input logic [15:0] id, input logic [15:0] exp, input string tag);
      i_ena = 1'b1; i_wea = 1'b0; i_id = id;
      #1 chk(32'(o_data), 32'(exp), tag);
      i_ena = 1'b0;
   endtask

   task automatic pulse(input logic [15:0] addr, input logic [7:0] d);
      i_cpu_address = addr; i_cpu_data = d; i_cpu_step_completed = 1'b1;
      @(posedge i_clk); #1;
      i_cpu_step_completed = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1; i_ena = 1'b0; i_wea = 1'b0; i_id = '0; i_data = '0;
      i_cpu_address = '0; i_cpu_data = '0; i_cpu_rw = 1'b1; i_cpu_sync = 1'b1;
      i_cpu_irq_n = 1'b1; i_cpu_nmi_n = 1'b0; i_cpu_regs = 48'hA1B2C3D4E5F6;
      i_cpu_step_completed = 1'b0;
      repeat (2) @(posedge i_clk);
      #1 i_reset = 1'b0;

      // Reset state
      chk(32'(o_halted), 1, "rst_halted");
      chk(32'(o_cpu_start_step), 0, "rst_start");
      rd(16'd1, 16'd0, "rst_ctrl");
      rd(16'd2, 16'd1, "rst_step_count");
      rd(16'd4, 16'd0, "rst_reason");
      rd(16'd3, 16'd0, "rst_rem");

      // Three-instruction step
      wr(16'd2, 16'd3);
      wr(16'd1, 16'd1);
      chk(32'(o_cpu_start_step), 1, "step_start");
      rd(16'd1, 16'd1, "step_state");
      rd(16'd3, 16'd3, "step_rem_init");
      pulse(16'h0010, 8'h11);
      pulse(16'h0012, 8'h22);
      chk(32'(o_cpu_start_step), 1, "step_start_mid");
      rd(16'd3, 16'd1, "step_rem_mid");
      pulse(16'h0014, 8'h33);
      chk(32'(o_cpu_start_step), 0, "step_start_end");
      chk(32'(o_halted), 1, "step_halted");
      rd(16'd4, 16'd1, "step_reason");
      rd(16'd3, 16'd0, "step_rem_end");
      rd(16'd9, 16'h00F6, "snap_a");
      rd(16'd14, 16'h00A1, "snap_ir");
      rd(16'd8, 16'h0007, "snap_flags");
      rd(16'd6, 16'h0014, "snap_addr_step");

      // Breakpoints: bp2 enabled, bp1 same address but disabled
      wr(16'd20, 16'hC004);
      wr(16'd21, 16'd1);
      wr(16'd18, 16'hC004);
      rd(16'd20, 16'hC004, "bp2_addr");
      rd(16'd21, 16'd1, "bp2_en");
      rd(16'd19, 16'd0, "bp1_en");
      wr(16'd1, 16'd2);
      rd(16'd1, 16'd2, "run_state");
      wr(16'd2, 16'd7);
      rd(16'd2, 16'd3, "run_stepcnt_ignored");
      pulse(16'hC000, 8'h01);
      pulse(16'hC002, 8'h02);
      chk(32'(o_cpu_start_step), 1, "run_start_mid");
      pulse(16'hC004, 8'h03);
      chk(32'(o_cpu_start_step), 0, "bp_start");
      rd(16'd4, 16'd2, "bp_reason");
      rd(16'd5, 16'd2, "bp_hit");
      rd(16'd6, 16'hC004, "bp_snap_addr");

      // Host halt coinciding with a breakpoint completion
      wr(16'd16, 16'hC004);
      wr(16'd17, 16'd1);
      wr(16'd1, 16'd2);
      i_ena = 1'b1; i_wea = 1'b1; i_id = 16'd1; i_data = 16'd3;
      pulse(16'hC004, 8'h5A);
      i_ena = 1'b0; i_wea = 1'b0;
      chk(32'(o_halted), 1, "halt_halted");
      rd(16'd4, 16'd3, "halt_reason");
      rd(16'd7, 16'h005A, "halt_snap_data");

      // Trailing completion in IDLE updates only the snapshot
      pulse(16'h1234, 8'h77);
      rd(16'd6, 16'h1234, "idle_snap_addr");
      rd(16'd4, 16'd3, "idle_reason_kept");
      rd(16'd1, 16'd0, "idle_state_kept");

      // Zero step count stored as 1
      wr(16'd2, 16'd0);
      rd(16'd2, 16'd1, "stepcnt_zero");
      wr(16'd1, 16'd1);
      pulse(16'h0100, 8'h00);
      chk(32'(o_cpu_start_step), 0, "step1_start");
      rd(16'd4, 16'd1, "step1_reason");

      // Max step count, then host halt keeps remaining count
      wr(16'd2, 16'hFFFF);
      rd(16'd2, 16'hFFFF, "stepcnt_max");
      wr(16'd1, 16'd1);
      pulse(16'h0200, 8'h00);
      rd(16'd3, 16'hFFFE, "max_rem");
      chk(32'(o_cpu_start_step), 1, "max_running");
      wr(16'd1, 16'd3);
      rd(16'd4, 16'd3, "max_halt_reason");
      rd(16'd3, 16'hFFFE, "max_rem_held");

      // Reset during RUN
      wr(16'd1, 16'd2);
      chk(32'(o_cpu_start_step), 1, "pre_rst_run");
      i_reset = 1'b1;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      chk(32'(o_cpu_start_step), 0, "rst2_start");
      chk(32'(o_halted), 1, "rst2_halted");
      rd(16'd1, 16'd0, "rst2_ctrl");
      rd(16'd2, 16'd1, "rst2_stepcnt");
      rd(16'd3, 16'd0, "rst2_rem");
      rd(16'd4, 16'd0, "rst2_reason");
      rd(16'd5, 16'd0, "rst2_bphit");
      rd(16'd6, 16'd0, "rst2_snap_addr");
      rd(16'd9, 16'd0, "rst2_snap_a");
      rd(16'd16, 16'd0, "rst2_bp0_addr");
      rd(16'd17, 16'd0, "rst2_bp0_en");

      // Halt write in IDLE has no effect; disabled access reads 0
      wr(16'd1, 16'd3);
      rd(16'd4, 16'd0, "idle_halt_reason");
      i_ena = 1'b0; i_id = 16'd2;
      #1 chk(32'(o_data), 0, "ena0_data");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/debug_values_ctrl.md
# debug_values_ctrl

Parametrised debugger value bank and CPU run controller. It sits between the host-side debugger access port and the CPU step interface. It provides a readable/writable ID-addressed value space, multi-instruction stepping, free-run with up to NUM_BREAKPOINTS address breakpoints, host halt, and a CPU state snapshot captured at every completed instruction.

## Interface
- DATA_WIDTH, 16, width of i_data/o_data (>=16)
- NUM_BREAKPOINTS, 4, number of address breakpoints (1..8)
- STEP_COUNT_WIDTH, 16, width of step counter (<= DATA_WIDTH)
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_ena  in  1  access enable
- i_wea  in  1  write enable (qualified by i_ena)
- i_id  in  16  value ID
- i_data  in  DATA_WIDTH  write data
- o_data  out  DATA_WIDTH  read data, combinational; 0 when i_ena=0
- i_cpu_address  in  16  CPU address bus
- i_cpu_data  in  8  CPU data bus
- i_cpu_rw, i_cpu_sync, i_cpu_irq_n, i_cpu_nmi_n  in  1 each  CPU status
- i_cpu_regs  in  48  {IR,P,S,Y,X,A}, A in [7:0]
- o_cpu_start_step  out  1  level: CPU may execute instructions while high
- i_cpu_step_completed  in  1  one-cycle pulse per completed instruction
- o_halted  out  1  1 when state is IDLE

## Operation
- States: IDLE (reset), STEP, RUN. o_cpu_start_step = (state != IDLE); o_halted = (state == IDLE).
- ID map (reads zero-extended; unmapped IDs read 0, writes ignored):
  - 1 CONTROL. Write 1 = step, 2 = run, 3 = halt; other values ignored. Read = state (0 IDLE, 1 STEP, 2 RUN).
  - 2 STEP_COUNT. R/W; reset value 1; a written 0 is stored as 1.
  - 3 STEPS_REMAINING. Read only.
  - 4 HALT_REASON. Read only: 0 none, 1 count done, 2 breakpoint, 3 host halt.
  - 5 BP_HIT. Index of the breakpoint that hit.
  - 6 SNAP_ADDRESS, 7 SNAP_DATA, 8 SNAP_FLAGS {nmi_n,irq_n,sync,rw} in [3:0].
  - 9..14 SNAP A, X, Y, S, P, IR.
  - 16+2k BP_ADDR[k]: 16-bit R/W.
  - 17+2k BP_EN[k]: bit 0 R/W.
- IDLE transitions:
  - step write → STEP, STEPS_REMAINING = STEP_COUNT, HALT_REASON = 0.
  - run write → RUN, HALT_REASON = 0.
  - halt write in IDLE → no effect.
- In STEP or RUN, step/run writes and STEP_COUNT writes are ignored. BP writes are always accepted.
- On i_cpu_step_completed, in any state: snapshot all CPU inputs.
  - In STEP, STEPS_REMAINING decrements.
  - Breakpoint check (STEP and RUN only): i_cpu_address equals BP_ADDR[k] with BP_EN[k]=1. The lowest k wins. Result: → IDLE, reason 2, BP_HIT = k.
  - Otherwise, in STEP with STEPS_REMAINING = 1: → IDLE, reason 1.
- Halt write in STEP or RUN: → IDLE, reason 3. STEPS_REMAINING holds its value.
- Priority when halt write and completion coincide: snapshot and decrement still occur; reason = 3 (host halt beats breakpoint beats count).
- A completion pulse received in IDLE (the trailing instruction after a halt) updates only the snapshot.

## Timing
- All state and register updates take effect on the i_clk edge after the write or completion. o_cpu_start_step rises 1 cycle after a step/run write.
- o_cpu_start_step falls on the edge following the terminating completion pulse, i.e. it is low in the cycle after the pulse.
- Snapshot values are readable the cycle after the pulse.
- Reset values:
  - state IDLE; o_cpu_start_step 0; o_halted 1.
  - STEP_COUNT 1; STEPS_REMAINING 0; HALT_REASON 0; BP_HIT 0.
  - all BP_ADDR 0 and BP_EN 0; snapshot 0.
- Reset asserted mid-STEP or mid-RUN → IDLE next edge, o_cpu_start_step 0.
- STEP_COUNT at max value (0xFFFF) counts the full range without wrap.

## Test plan
- Reset; read IDs 1, 2, 4 → 0, 1, 0; o_halted = 1.
- Write STEP_COUNT = 3, CONTROL = 1; pulse completion 3× → o_cpu_start_step high for the whole window, low after the 3rd pulse. HALT_REASON = 1, STEPS_REMAINING = 0.
- BP_ADDR[2] = 0xC004, BP_EN[2] = 1, BP_ADDR[1] = 0xC004 (disabled). Run; complete with addresses 0xC000, 0xC002, 0xC004 → halt after the 3rd. Reason 2, BP_HIT = 2, SNAP_ADDRESS = 0xC004.
- Run, then write CONTROL = 3 in the same cycle as a completion at 0xC004 with BP_EN[0] = 1, BP_ADDR[0] = 0xC004 → reason 3, snapshot updated.
- STEP_COUNT write of 0 → reads 1. Step → halts after 1 pulse.
- Assert i_reset during RUN → next cycle o_cpu_start_step = 0, all IDs read reset values; o_data = 0 with i_ena = 0 for any ID.
